// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_bank
// Purpose  : Bank of independent glitch-free 50%-duty clock dividers with
//            per-channel polarity and a one-cycle tick on each logical rising
//            edge. Ratio and polarity writes are staged and only take effect
//            at period boundaries or while stopped.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_bank #(
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 8,
  parameter int RESET_DIV = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [CHANNELS-1:0]  en_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CW-1:0]        cfg_chan_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_invert_i,
  output logic [CHANNELS-1:0]  clk_o,
  output logic [CHANNELS-1:0]  tick_o
);

  localparam logic [DIV_WIDTH-1:0] C_RESET_DIV = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] C_ONE       = DIV_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Pending flags of all channels, padded so any cfg_chan_i value can index it;
  // out-of-range slots read as "not pending" so such writes are always accepted.
  logic [CHANNELS-1:0] pend_vec;
  logic [2**CW-1:0]    pend_ext;

  for (genvar j = 0; j < 2**CW; j++) begin : g_pad
    if (j < CHANNELS) begin : g_real
      assign pend_ext[j] = pend_vec[j];
    end else begin : g_oor
      assign pend_ext[j] = 1'b0;
    end
  end

  assign cfg_ready_o = !pend_ext[cfg_chan_i];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    state_t               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] pdiv_q;
    logic                 inv_q;
    logic                 pinv_q;
    logic                 pend_q;
    logic                 clk_q;
    logic                 tick_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic                 inv_d;
    logic                 wr_d;

    // A write lands here only when this channel has nothing pending.
    assign wr_d  = cfg_valid_i && cfg_ready_o && (cfg_chan_i == CW'(i));
    // Settings in force after a boundary: the staged ones if any are pending.
    assign div_d = pend_q ? pdiv_q : div_q;
    assign inv_d = pend_q ? pinv_q : inv_q;

    // Divider FSM: counts half-periods, applies staged settings only at
    // boundaries, and registers both the output clock and the tick.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        state_q <= ST_STOP;
        cnt_q   <= '0;
        div_q   <= C_RESET_DIV;
        inv_q   <= 1'b0;
        pdiv_q  <= C_RESET_DIV;
        pinv_q  <= 1'b0;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (wr_d) begin
          pend_q <= 1'b1;
          pdiv_q <= cfg_div_i;
          pinv_q <= cfg_invert_i;
        end
        case (state_q)
          ST_STOP: begin
            if (pend_q) begin
              // Applying a polarity while idle is a single level step.
              div_q  <= pdiv_q;
              inv_q  <= pinv_q;
              pend_q <= 1'b0;
              clk_q  <= pinv_q;
            end else if (en_i[i]) begin
              state_q <= ST_HIGH;
              cnt_q   <= div_q;
              tick_q  <= 1'b1;
              clk_q   <= ~inv_q;
            end
          end
          ST_HIGH: begin
            if (cnt_q == '0) begin
              state_q <= ST_LOW;
              cnt_q   <= div_q;
              clk_q   <= inv_q;
            end else begin
              cnt_q <= cnt_q - C_ONE;
            end
          end
          ST_LOW: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - C_ONE;
            end else begin
              // Period boundary: the only place a running channel changes.
              div_q <= div_d;
              inv_q <= inv_d;
              if (pend_q) begin
                pend_q <= 1'b0;
              end
              if (en_i[i]) begin
                state_q <= ST_HIGH;
                cnt_q   <= div_d;
                tick_q  <= 1'b1;
                clk_q   <= ~inv_d;
              end else begin
                state_q <= ST_STOP;
                clk_q   <= inv_d;
              end
            end
          end
          default: begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            clk_q   <= inv_q;
          end
        endcase
      end
    end

    assign pend_vec[i] = pend_q;
    assign clk_o[i]    = clk_q;
    assign tick_o[i]   = tick_q;
  end

endmodule
`default_nettype wire

// File: doc/clock_divider_bank.md
# clock_divider_bank

Bank of independently programmable, glitch-free clock dividers, all derived from one source clock. Each channel produces a registered 50 %-duty divided clock with optional polarity inversion and a one-cycle tick marking each logical rising edge. Ratio and polarity updates are staged and applied only at period boundaries, so no runt pulses are ever emitted. Sits in the clock block next to the clock inverter and feeds slow peripheral clock domains and their clock-enable logic.

## Interface
- CHANNELS, 2: number of divider channels (≥1)
- DIV_WIDTH, 8: width of the divisor field
- RESET_DIV, 0: divisor loaded into every channel at reset
- clk_i  input  1  source clock
- reset_n_i  input  1  reset; one clock, synchronous, active-low
- en_i  input  CHANNELS  per-channel run enable
- cfg_valid_i  input  1  config write request
- cfg_ready_o  output  1  config write can be accepted
- cfg_chan_i  input  max(1,$clog2(CHANNELS))  target channel
- cfg_div_i  input  DIV_WIDTH  new divisor d
- cfg_invert_i  input  1  new polarity (1 = inverted output)
- clk_o  output  CHANNELS  divided clocks, registered
- tick_o  output  CHANNELS  one-cycle pulse per logical rising edge, registered

## Operation
- Per channel: active divisor `div`, active `inv`, pending flag, pending divisor/polarity, down-counter `cnt` (DIV_WIDTH bits), state STOP/HIGH/LOW.
- Logical phase: 1 in HIGH, 0 in STOP/LOW; clk_o = phase XOR inv.
- Half-period = div+1 cycles; full period = 2·(div+1) cycles of clk_i; d=0 gives clk_i/2, d=2^DIV_WIDTH−1 gives clk_i/2^(DIV_WIDTH+1). Duty always exactly 50 %.
- STOP: if pending, apply it (div, inv ← pending; clear pending) and stay STOP this cycle; else if en_i: → HIGH, cnt ← div, tick_o=1 with the transition.
- HIGH: cnt==0 → LOW, cnt ← div; else cnt−1.
- LOW: cnt≠0 → cnt−1. cnt==0 is the period boundary: new div/inv ← pending if pending set (clear pending); then if en_i → HIGH, cnt ← new div, tick_o=1; else → STOP.
- en_i deasserted mid-period: channel completes the current period, then enters STOP; never truncates a phase.
- Config handshake: write accepted when cfg_valid_i && cfg_ready_o; stores divisor/polarity into target's pending regs, sets pending. cfg_ready_o = !pending[cfg_chan_i] (combinational from cfg_chan_i). cfg_chan_i ≥ CHANNELS: cfg_ready_o=1, write accepted and discarded.
- Write accepted in a boundary cycle: boundary uses pre-write pending state; new value applied at next boundary (or next STOP cycle).
- Polarity change while stopped changes idle level of clk_o once, by a level step, never a pulse.
- Channels fully independent; no phase relation guaranteed between channels unless enabled in the same cycle with equal div.

## Timing
- Reset (reset_n_i low at a clk_i edge): next cycle all clk_o=0, tick_o=0, state STOP, cnt=0, div=RESET_DIV, inv=0, pending=0; cfg_ready_o=1. Reset mid-period aborts immediately; truncation accepted only under reset.
- Enable latency: en_i sampled high in STOP at edge t → clk_o logical high and tick_o=1 from edge t (visible cycle t+1). tick_o high exactly one cycle per period.
- Config latency: accepted at edge t on a stopped channel → applied at edge t+1; visible in clk_o from t+1 (inv) or next enable (div).
- Config on running channel: takes effect at first period boundary after acceptance; current period completes with old div/inv.
- cfg_ready_o for a channel stays low from acceptance until the edge applying the pending value.

## Test plan
- Reset/idle: hold reset_n_i low 3 cycles, release, en_i=0 → clk_o=0, tick_o=0, cfg_ready_o=1 for 20 cycles.
- Ratio: RESET_DIV=0, en_i[0]=1 → clk_o[0] toggles every cycle (period 2), tick_o[0] every 2nd cycle; write d=2 to ch1 then enable → period 6, high 3 cycles, tick every 6.
- Glitch-free update: ch0 running d=3; write d=0 mid-HIGH → remaining high+low phases stay 4 cycles each, then period 2; cfg_ready_o low with cfg_chan_i=0 until boundary, second write held off.
- Invert: write inv=1 while stopped → clk_o goes to 1 next cycle, tick_o stays 0; enable → clk_o low for div+1, tick coincides with logical rise.
- Disable: deassert en_i 1 cycle into HIGH with d=4 → full 5 high + 5 low cycles complete, then STOP at idle level, no further ticks.
- Out-of-range/reset mid-run: CHANNELS=3, write cfg_chan_i=3 → accepted, no channel changes; assert reset_n_i mid-HIGH → all outputs 0 next cycle.
